demux1to8_collect: RTL

DEMUX1TO8_COLLECT -- requirements
Module: demux1to8_collect

---
 rtl/demux1to8_collect.sv | 139 +++++++++++++
 1 files changed

// File: rtl/demux1to8_collect.sv
// rtl/demux1to8_collect.sv - serial bit collector that assembles 8 addressed bits into a word with a valid/ready output
// Optional feature: define DEMUX_DUP_CHECK_EN to flag slots written twice within one word on dup_err.
module demux1to8_collect (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       valid,
  input  logic       din,
  input  logic [2:0] addy,
  output logic [7:0] q,
  output logic       q_valid,
  input  logic       q_ready,
  output logic [7:0] fill,
  output logic       busy,
  output logic       drop,
  output logic       dup_err
);

  typedef enum logic {
    COLLECT = 1'b0,
    STALL   = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [7:0] asm_r;
  logic [7:0] asm_nxt;
  logic [7:0] fill_nxt;
  logic [7:0] q_nxt;
  logic       q_valid_nxt;
  logic       drop_nxt;

  logic [7:0] onehot;
  logic [7:0] asm_written;
  logic [7:0] fill_merged;
  logic       wr;
  logic       complete;
  logic       can_load;

  // Decode of the incoming bit: which slot, what the word looks like with it, and whether it finishes the word.
  always_comb begin
    onehot      = 8'd1 << addy;
    wr          = en & valid & (state == COLLECT);
    asm_written = (asm_r & ~onehot) | ({8{din}} & onehot);
    fill_merged = fill | onehot;
    complete    = wr & (fill_merged == 8'hFF);
    // The output register is free if empty or being drained on this very edge.
    can_load    = ~q_valid | q_ready;
  end

  // Next-state and datapath update; every target holds its value unless an event below changes it.
  always_comb begin
    state_nxt   = state;
    asm_nxt     = asm_r;
    fill_nxt    = fill;
    q_nxt       = q;
    q_valid_nxt = q_valid;
    drop_nxt    = drop;
    case (state)
      COLLECT: begin
        // Plain drain; overridden below when a completed word takes its place with no gap.
        if (q_valid && q_ready) begin
          q_valid_nxt = 1'b0;
        end
        if (wr) begin
          asm_nxt = asm_written;
          if (complete) begin
            if (can_load) begin
              q_nxt       = asm_written;
              q_valid_nxt = 1'b1;
              fill_nxt    = 8'h00;
            end else begin
              // Output still occupied: park the finished word in asm until the consumer drains.
              fill_nxt  = 8'hFF;
              state_nxt = STALL;
            end
          end else begin
            fill_nxt = fill_merged;
          end
        end
      end
      STALL: begin
        if (en && valid) begin
          drop_nxt = 1'b1;
        end
        // q_valid is necessarily 1 here, so a ready edge both drains the old word and loads the parked one.
        if (q_ready) begin
          q_nxt       = asm_r;
          q_valid_nxt = 1'b1;
          fill_nxt    = 8'h00;
          state_nxt   = COLLECT;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // Assembly, output and sticky-status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_r   <= 8'h00;
      fill    <= 8'h00;
      q       <= 8'h00;
      q_valid <= 1'b0;
      drop    <= 1'b0;
    end else begin
      asm_r   <= asm_nxt;
      fill    <= fill_nxt;
      q       <= q_nxt;
      q_valid <= q_valid_nxt;
      drop    <= drop_nxt;
    end
  end

`ifdef DEMUX_DUP_CHECK_EN
  // Sticky flag for a slot rewritten before its word completed; the new bit still overwrites.
  always_ff @(posedge clk) begin
    if (rst) begin
      dup_err <= 1'b0;
    end else if (wr && ((fill & onehot) != 8'h00)) begin
      dup_err <= 1'b1;
    end
  end
`else
  assign dup_err = 1'b0;
`endif

  assign busy = (state == STALL);

endmodule
